// File: rtl/ldl_fifo_stream_reader.sv
// FIFO read-port to valid/ready stream adapter. A 2-entry skid buffer absorbs
// the FIFO read latency so the consumer may stall on any cycle at full rate.
module ldl_fifo_stream_reader #(
    parameter int DW    = 8,
    parameter bit AHEAD = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          re,
    input  logic          empty,
    input  logic [DW-1:0] dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    level
);

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic               pop;
    logic               capture;
    logic [1:0]         committed;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign level   = occ_q;

    always_comb begin
        pop        = m_valid && m_ready;
        // Words already owned by the buffer after this cycle's pop; re must be
        // combinational on pop, otherwise a full buffer cannot refill on release.
        committed  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        re         = rst_n && !empty && (committed < 2'd2);
        capture    = AHEAD ? re : inflight_q;
        inflight_d = AHEAD ? 1'b0 : re;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (capture) begin
            mem_d[wr_ptr_q] = dout;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: doc/ldl_fifo_stream_reader.md
# ldl_fifo_stream_reader

Read-side adapter that drains a FIFO read port (`re`/`empty`/`dout`, show-ahead or registered-output) and presents the words as a valid/ready stream with full throughput and no bubbles. Sits between the read side of `LDL_afifo_v1` (or any single-clock FIFO with the same read port) and a downstream consumer that may stall arbitrarily. An internal 2-entry skid buffer absorbs the FIFO read latency, so `m_ready` may drop at any cycle without losing data.

## Interface
- `DW`, 8: data width.
- `AHEAD`, 0: FIFO read mode. 1 means show-ahead: `dout` is valid whenever `empty`=0, and `re` pops it. 0 means registered: `dout` is valid in the cycle after `re`&&~`empty`.

- `clk` in 1: clock; must be the FIFO read clock.
- `rst_n` in 1: asynchronous active-low reset.
- `re` out 1: FIFO read enable.
- `empty` in 1: FIFO empty flag.
- `dout` in DW: FIFO read data.
- `m_valid` out 1: stream word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out DW: stream word, the head of the buffer.
- `level` out 2: number of words held in the buffer, 0..2.

## Operation
- Buffer: 2 entries, with 1-bit write and read pointers and a 2-bit `occ`. `m_valid` = (`occ`!=0). `m_data` = entry[rd_ptr]. `level` = `occ`.
- `pop` = `m_valid`&&`m_ready`. On a pop, rd_ptr advances.
- AHEAD=0:
  - `inflight` register is set to `re`&&~`empty` at each edge.
  - When `inflight`=1, `dout` is written into entry[wr_ptr] at that edge.
  - `re` = ~`empty` && (`occ` + `inflight` − `pop` < 2).
- AHEAD=1:
  - `inflight` is tied to 0.
  - `re` = ~`empty` && (`occ` − `pop` < 2).
  - `dout` is written into the buffer at the same edge that `re`&&~`empty` is sampled.
- `occ`(next) = `occ` + capture − `pop`, where capture = (AHEAD ? `re`&&~`empty` : `inflight`). All counter arithmetic is unsigned 2-bit. `occ`+`inflight` never exceeds 2 by construction.
- Capture and pop in the same cycle: both take effect, `occ` is unchanged, and pointers advance independently. Wrap-around is natural 1-bit pointer overflow.
- `re` is combinational from registered state, `empty` and `m_ready`. This path is intentional and must not be registered, because registering it halves throughput.
- `re` is never asserted while `empty`=1 or while `rst_n`=0.
- Word order at `m_data` equals FIFO read order. No word is duplicated or dropped.
- Reset, including mid-operation:
  - `occ`, the pointers and `inflight` clear immediately.
  - Buffered words and any in-flight read are discarded.
  - The FIFO read side must be reset together with this block.

## Timing
- Reset values: `re`=0, `m_valid`=0, `m_data`=0 (all entries clear), `level`=0.
- Latency from `empty` falling, block idle, to `m_valid` rising:
  - AHEAD=1: 1 cycle. `re` goes high in cycle k and `m_valid` goes high in cycle k+1.
  - AHEAD=0: 2 cycles. `re` in cycle k, data captured at the end of k+1, `m_valid` in k+2.
- Throughput: 1 word per cycle in steady state while `m_ready`=1 and the FIFO stays non-empty, in both modes.
- Stall handling:
  - `m_ready`=0 with `m_valid`=1 holds `m_data` stable until accepted.
  - Under a persistent stall, `re` stops when `occ`+`inflight` reaches 2.
  - The buffer fills to 2 words, and then `re`=0 while `m_ready`=0.
- Release: the first cycle `m_ready`=1 with `occ`=2 yields `pop`=1 and `re`=~`empty` in that same cycle.
- `empty` rising while `inflight`=1 (AHEAD=0): the in-flight word is still captured, and no further `re` is issued.

## Test plan
- Burst, no stall:
  - Stimulus: FIFO preloaded with 0xa1..0xb4 (20 words), `m_ready`=1.
  - Required: `m_data` sequence 0xa1..0xb4 with `m_valid` high on 20 consecutive cycles, for both AHEAD=0 and AHEAD=1.
  - Required: first `m_valid` 1 cycle (AHEAD=1) or 2 cycles (AHEAD=0) after the first `re`.
- Stall:
  - Stimulus: 8 words in the FIFO, `m_ready`=0 for 10 cycles, then 1.
  - Required: `level` settles at 2, `re`=0 during the stall, and `m_data`=0xa1 is held.
  - Required: after release, 0xa1..0xa8 are delivered in order with no gaps.
- Random backpressure:
  - Stimulus: `m_ready` random at 50%, 200 words.
  - Required: scoreboard matches in order, zero errors, and `re` is never high while `empty`=1.
- Empty toggling:
  - Stimulus: FIFO gets one word every 3rd cycle, `m_ready`=1.
  - Required: each word appears exactly once, `level` ≤ 1, and no duplicate `m_data` acceptance.
- Reset mid-stream:
  - Stimulus: assert `rst_n`=0 while `level`=2 and `inflight`=1.
  - Required: outputs return to reset values in the same cycle (asynchronous).
  - Required: after release and FIFO reset, the new data 0xc1.. is delivered first, with no stale words.
